alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Execution unit on the responder side of the control-unit ↔ ALU interface.
- The control unit supplies aluctl, A (rs operand) and B (rt operand or extended immediate), and pulses start.
- The block returns alu_out_data with a one-cycle alu_ready pulse. Write-back then follows rd_we = alu_ready.
- Logic, shift, compare and add/sub ops take one cycle; mul/div are iterative (multi-cycle).

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- ITER, 32, iterations for mul/div; must equal XLEN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  op request; accepted only when busy=0
- aluctl  in  6  [5:1] op code, [0] immediate-form flag (ignored here; operand select is upstream)
- A  in  32  rs operand
- B  in  32  rt operand or extended immediate
- sh_amount  in  5  shift amount for constant shifts
- busy  out  1  high while in MUL or DIV
- alu_ready  out  1  one-cycle result-valid pulse
- alu_out_data  out  32  result
- hi_out  out  32  mul high word / div remainder; 0 for other ops
- zero  out  1  alu_out_data==0, valid with alu_ready
- overflow  out  1  signed overflow (add, sub), valid with alu_ready
- div_by_zero  out  1  divide with B==0, valid with alu_ready
- illegal  out  1  unsupported op code, valid with alu_ready

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: busy, alu_ready, alu_out_data, hi_out, zero, overflow, div_by_zero, illegal.
  - Reset mid-mul/div aborts the op; no alu_ready is produced.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE/DONE with start=1 and a single-cycle op → DONE. Result registered; alu_ready=1 the next cycle (latency 1).
  - IDLE/DONE with start=1 and op 12 → MUL; op 13 → DIV. Operands latched, counter=0.
  - MUL/DIV: one iteration per cycle. When counter reaches ITER-1 → DONE.
  - Result is valid at start+ITER+1 = 33 cycles.
  - DONE → IDLE when start=0. DONE with start=1 accepts a new op (back-to-back issue allowed).
- busy=1 in MUL and DIV only. start while busy is ignored; no queueing.
- alu_ready=1 exactly in DONE cycles. Outputs hold their last value in IDLE.
- Op codes (aluctl[5:1]):
  - 0 xor: A^B
  - 1 sll: B<<sh_amount
  - 2 sllv: A<<B[4:0]
  - 3 srl: B>>sh_amount (logical)
  - 4 sub: A-B, signed overflow flagged
  - 5 srlv: B>>A[4:0]
  - 6 slt: {31'b0, $signed(A)<$signed(B)}
  - 7 halt: result 0
  - 8 subu: A-B, no overflow
  - 9 or
  - 10 nor
  - 11 addu
  - 12 mul: signed 64-bit product; low word → alu_out_data, high word → hi_out
  - 13 div: signed, quotient truncated toward zero; remainder takes the dividend's sign
  - 14 and
  - 15 add: A+B, signed overflow flagged
  - 16 jr: A
  - 17 sra: arithmetic B>>>sh_amount
  - 18: A==B
  - 19: A!=B
  - 20: A<=0 signed
  - 21: A>0 signed
  - 22: A>=0 signed
  - Codes 18–22 return the condition in bit 0, other bits 0.
  - 23–26 (lw/sw/lb/sb): address A+B
  - 27 slti: same as slt
  - 28 lui: B<<16
- All other codes: result 0, illegal=1, latency 1.
- Overflow on add/sub still returns the wrapped result; the overflow flag is informational.
- Mul: radix-2 shift-add on operand magnitudes, sign applied at DONE.
- Div: restoring, on magnitudes.
- Div boundary cases:
  - B==0: quotient 0xFFFFFFFF, remainder=A, div_by_zero=1. Full 33-cycle latency is kept.
  - A=0x80000000, B=0xFFFFFFFF: quotient 0x80000000, remainder 0, no flag.
- zero is computed from the final alu_out_data for every op.

Optional Feature:
- Macro ALU_FAST_MUL_EN.
- Defined: op 12 uses a single-cycle combinational signed 32x32 multiply. Latency 1, busy never asserted for mul, MUL state unused.
- Undefined: iterative multiply as specified above (33-cycle latency).
- Divide is iterative in both builds.

Test Plan:
- add A=0x7FFFFFFF, B=1 → alu_ready 1 cycle after start, alu_out_data=0x80000000, overflow=1, zero=0.
- sra B=0xF0000000, sh_amount=4 → 0xFF000000. srl with the same operands → 0x0F000000. beq-code 18 with A=B=5 → 0x00000001.
- mul A=-3, B=7 → alu_ready exactly 33 cycles after start (1 cycle with ALU_FAST_MUL_EN); alu_out_data=0xFFFFFFEB, hi_out=0xFFFFFFFF.
- div A=-7, B=2 → quotient 0xFFFFFFFD, hi_out=0xFFFFFFFF. div B=0 → quotient 0xFFFFFFFF, div_by_zero=1.
- start pulsed during DIV busy with op 15 → ignored; only the div result appears. start asserted in the DONE cycle → accepted; second alu_ready follows 1 cycle later.
- rst_n low at cycle 10 of a mul → all outputs 0 immediately, no alu_ready. Op code 30 → illegal=1, result 0.

Source files
------------

// File: rtl/alu_multicycle.sv
`default_nettype none
// =============================================================================
// alu_multicycle : responder-side ALU. Single-cycle logic/shift/compare/add ops,
// iterative signed mul/div. Macro ALU_FAST_MUL_EN selects a one-cycle multiply.
// Revision: 1.0
// =============================================================================
module alu_multicycle #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [5:0]      aluctl,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic [4:0]      sh_amount,
   output logic            busy,
   output logic            alu_ready,
   output logic [XLEN-1:0] alu_out_data,
   output logic [XLEN-1:0] hi_out,
   output logic            zero,
   output logic            overflow,
   output logic            div_by_zero,
   output logic            illegal
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam logic [4:0] OP_MUL = 5'd12;
   localparam logic [4:0] OP_DIV = 5'd13;
   localparam logic [4:0] LAST   = 5'(ITER - 1);
`ifdef ALU_FAST_MUL_EN
   localparam bit FAST_MUL = 1'b1;
`else
   localparam bit FAST_MUL = 1'b0;
`endif

   state_t      state, next_state;
   logic [4:0]  op;
   logic        unused_imm;
   logic        accept, go_mul, go_div;

   assign op         = aluctl[5:1];
   assign unused_imm = aluctl[0];
   assign accept     = start && (state == S_IDLE || state == S_DONE);
   assign go_div     = (op == OP_DIV);
   assign go_mul     = (op == OP_MUL) && !FAST_MUL;
   assign busy       = (state == S_MUL) || (state == S_DIV);
   assign alu_ready  = (state == S_DONE);

   function automatic logic [31:0] mag(input logic [31:0] v);
      return v[31] ? -v : v;
   endfunction

   // ---------------- single-cycle datapath ----------------
   logic [31:0] sum, diff, sc_res, sc_hi;
   logic        sc_ovf, sc_ill;

   assign sum  = A + B;
   assign diff = A - B;

`ifdef ALU_FAST_MUL_EN
   logic signed [63:0] fast_prod;
   assign fast_prod = $signed(A) * $signed(B);
`endif

   always_comb begin
      sc_res = '0;
      sc_hi  = '0;
      sc_ovf = 1'b0;
      sc_ill = 1'b0;
      case (op)
         5'd0:  sc_res = A ^ B;
         5'd1:  sc_res = B << sh_amount;
         5'd2:  sc_res = A << B[4:0];
         5'd3:  sc_res = B >> sh_amount;
         5'd4:  begin
            sc_res = diff;
            sc_ovf = (A[31] != B[31]) && (diff[31] != A[31]);
         end
         5'd5:  sc_res = B >> A[4:0];
         5'd6, 5'd27: sc_res = {31'b0, $signed(A) < $signed(B)};
         5'd7:  sc_res = '0;
         5'd8:  sc_res = diff;
         5'd9:  sc_res = A | B;
         5'd10: sc_res = ~(A | B);
         5'd11: sc_res = sum;
         OP_MUL: begin
`ifdef ALU_FAST_MUL_EN
            sc_res = fast_prod[31:0];
            sc_hi  = fast_prod[63:32];
`endif
         end
         OP_DIV: sc_res = '0;
         5'd14: sc_res = A & B;
         5'd15: begin
            sc_res = sum;
            sc_ovf = (A[31] == B[31]) && (sum[31] != A[31]);
         end
         5'd16: sc_res = A;
         5'd17: sc_res = 32'($signed(B) >>> sh_amount);
         5'd18: sc_res = {31'b0, A == B};
         5'd19: sc_res = {31'b0, A != B};
         5'd20: sc_res = {31'b0, A[31] || (A == '0)};
         5'd21: sc_res = {31'b0, !A[31] && (A != '0)};
         5'd22: sc_res = {31'b0, !A[31]};
         5'd23, 5'd24, 5'd25, 5'd26: sc_res = sum;
         5'd28: sc_res = B << 16;
         default: sc_ill = 1'b1;
      endcase
   end

   // ---------------- iterative mul/div ----------------
   logic [4:0]  cnt;
   logic [31:0] mag_a;
   logic [63:0] prod;
   logic        neg_p;
   logic [31:0] dmag, quo, rem, div_a;
   logic        neg_q, neg_r, dz;

   // Shift-add: accumulate in the upper half while the multiplier shifts out below.
   logic [32:0] mul_sum;
   logic [63:0] prod_nx, mul_fin;
   assign mul_sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mag_a} : 33'd0);
   assign prod_nx = {mul_sum, prod[31:1]};
   assign mul_fin = neg_p ? -prod_nx : prod_nx;

   logic [32:0] rem_sh, trial;
   logic [31:0] rem_nx, quo_nx, q_fin, r_fin;
   assign rem_sh = {rem, quo[31]};
   assign trial  = rem_sh - {1'b0, dmag};
   assign rem_nx = trial[32] ? rem_sh[31:0] : trial[31:0];
   assign quo_nx = {quo[30:0], ~trial[32]};
   assign q_fin  = dz ? 32'hFFFF_FFFF : (neg_q ? -quo_nx : quo_nx);
   assign r_fin  = dz ? div_a : (neg_r ? -rem_nx : rem_nx);

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start)
               next_state = go_div ? S_DIV : (go_mul ? S_MUL : S_DONE);
            else
               next_state = S_IDLE;
         end
         S_MUL, S_DIV: if (cnt == LAST) next_state = S_DONE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         mag_a        <= '0;
         prod         <= '0;
         neg_p        <= 1'b0;
         dmag         <= '0;
         quo          <= '0;
         rem          <= '0;
         div_a        <= '0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         dz           <= 1'b0;
         alu_out_data <= '0;
         hi_out       <= '0;
         zero         <= 1'b0;
         overflow     <= 1'b0;
         div_by_zero  <= 1'b0;
         illegal      <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            cnt <= '0;
            if (go_mul) begin
               mag_a <= mag(A);
               prod  <= {32'd0, mag(B)};
               neg_p <= A[31] ^ B[31];
            end else if (go_div) begin
               dmag  <= mag(B);
               quo   <= mag(A);
               rem   <= '0;
               div_a <= A;
               neg_q <= A[31] ^ B[31];
               neg_r <= A[31];
               dz    <= (B == '0);
            end else begin
               alu_out_data <= sc_res;
               hi_out       <= sc_hi;
               zero         <= (sc_res == '0);
               overflow     <= sc_ovf;
               div_by_zero  <= 1'b0;
               illegal      <= sc_ill;
            end
         end else if (state == S_MUL) begin
            prod <= prod_nx;
            cnt  <= cnt + 5'd1;
            if (cnt == LAST) begin
               alu_out_data <= mul_fin[31:0];
               hi_out       <= mul_fin[63:32];
               zero         <= (mul_fin[31:0] == '0);
               overflow     <= 1'b0;
               div_by_zero  <= 1'b0;
               illegal      <= 1'b0;
            end
         end else if (state == S_DIV) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 5'd1;
            if (cnt == LAST) begin
               alu_out_data <= q_fin;
               hi_out       <= r_fin;
               zero         <= (q_fin == '0);
               overflow     <= 1'b0;
               div_by_zero  <= dz;
               illegal      <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// tb_alu_multicycle : scoreboard bench for alu_multicycle (directed, corner and random ops).
module tb_alu_multicycle;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [5:0]  aluctl = '0;
   logic [31:0] A = '0, B = '0;
   logic [4:0]  sh_amount = '0;
   logic        busy, alu_ready, zero, overflow, div_by_zero, illegal;
   logic [31:0] alu_out_data, hi_out;

   always #5 clk = ~clk;

   alu_multicycle #(.XLEN(32), .ITER(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .aluctl(aluctl), .A(A), .B(B),
      .sh_amount(sh_amount), .busy(busy), .alu_ready(alu_ready),
      .alu_out_data(alu_out_data), .hi_out(hi_out), .zero(zero),
      .overflow(overflow), .div_by_zero(div_by_zero), .illegal(illegal)
   );

`ifdef ALU_FAST_MUL_EN
   localparam logic [7:0] MUL_LAT = 8'd1;
`else
   localparam logic [7:0] MUL_LAT = 8'd33;
`endif

   // flags = {zero, overflow, div_by_zero, illegal}
   typedef struct packed {
      logic [31:0] data;
      logic [31:0] hi;
      logic [3:0]  flags;
      logic [7:0]  lat;
   } exp_t;

   typedef struct {
      string       nm;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic ovf32(input longint s);
      logic signed [31:0] t;
      t = s[31:0];
      return longint'(t) != s;
   endfunction

   function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh);
      exp_t   e;
      longint la, lb, s, r;
      e = '0;
      e.lat = 8'd1;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      case (op)
         0:  e.data = a ^ b;
         1:  e.data = b << sh;
         2:  e.data = a << (a - a + b[4:0]);
         3:  e.data = b >> sh;
         4:  begin s = la - lb; e.data = s[31:0]; e.flags[2] = ovf32(s); end
         5:  e.data = b >> a[4:0];
         6, 27: e.data = (la < lb) ? 32'd1 : 32'd0;
         7:  e.data = 32'd0;
         8:  e.data = a - b;
         9:  e.data = a | b;
         10: e.data = ~(a | b);
         11: e.data = a + b;
         12: begin s = la * lb; e.data = s[31:0]; e.hi = s[63:32]; e.lat = MUL_LAT; end
         13: begin
            e.lat = 8'd33;
            if (b == 32'd0) begin
               e.data = 32'hFFFF_FFFF; e.hi = a; e.flags[1] = 1'b1;
            end else begin
               s = la / lb; r = la % lb;
               e.data = s[31:0]; e.hi = r[31:0];
            end
         end
         14: e.data = a & b;
         15: begin s = la + lb; e.data = s[31:0]; e.flags[2] = ovf32(s); end
         16: e.data = a;
         17: begin s = lb >>> sh; e.data = s[31:0]; end
         18: e.data = (a == b) ? 32'd1 : 32'd0;
         19: e.data = (a != b) ? 32'd1 : 32'd0;
         20: e.data = (la <= 0) ? 32'd1 : 32'd0;
         21: e.data = (la > 0) ? 32'd1 : 32'd0;
         22: e.data = (la >= 0) ? 32'd1 : 32'd0;
         23, 24, 25, 26: e.data = a + b;
         28: e.data = {b[15:0], 16'h0000};
         default: e.flags[0] = 1'b1;
      endcase
      e.flags[3] = (e.data == 32'd0);
      return e;
   endfunction

   // Drives one op, pushes its expectation, waits (bounded) for alu_ready and pops it.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output exp_t e, output exp_t got, output logic to);
      int cyc;
      @(negedge clk);
      aluctl = {op, 1'b0}; A = a; B = b; sh_amount = sh; start = 1'b1;
      sb.push_back(model(op, a, b, sh));
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!alu_ready && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      to = !alu_ready;
      e = sb.pop_front();
      got.data  = alu_out_data;
      got.hi    = hi_out;
      got.flags = {zero, overflow, div_by_zero, illegal};
      got.lat   = cyc[7:0];
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, alu_ready, alu_out_data, hi_out, zero, overflow, div_by_zero, illegal} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got busy=%b rdy=%b data=%h hi=%h flags=%b%b%b%b, want all 0",
                  busy, alu_ready, alu_out_data, hi_out, zero, overflow, div_by_zero, illegal);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_ops();
      vec_t tbl[$];
      exp_t e, got;
      logic to;
      tbl.push_back('{"add_ovf",  5'd15, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0});
      tbl.push_back('{"sra",      5'd17, 32'h0,         32'hF000_0000, 5'd4});
      tbl.push_back('{"srl",      5'd3,  32'h0,         32'hF000_0000, 5'd4});
      tbl.push_back('{"beq",      5'd18, 32'd5,         32'd5,         5'd0});
      tbl.push_back('{"mul_neg",  5'd12, 32'hFFFF_FFFD, 32'd7,         5'd0});
      tbl.push_back('{"div_neg",  5'd13, 32'hFFFF_FFF9, 32'd2,         5'd0});
      tbl.push_back('{"div_zero", 5'd13, 32'h1234_5678, 32'd0,         5'd0});
      tbl.push_back('{"div_min",  5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0});
      tbl.push_back('{"div_rneg", 5'd13, 32'd7,         32'hFFFF_FFFE, 5'd0});
      tbl.push_back('{"mul_min",  5'd12, 32'h8000_0000, 32'h8000_0000, 5'd0});
      tbl.push_back('{"illegal",  5'd30, 32'h1111_1111, 32'h2222_2222, 5'd0});
      tbl.push_back('{"sub_ovf",  5'd4,  32'h8000_0000, 32'd1,         5'd0});
      tbl.push_back('{"slt",      5'd6,  32'hFFFF_FFFF, 32'd1,         5'd0});
      tbl.push_back('{"lui",      5'd28, 32'h0,         32'h0000_1234, 5'd0});
      tbl.push_back('{"xor_zero", 5'd0,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd0});
      tbl.push_back('{"sllv",     5'd2,  32'h0000_0003, 32'hFFFF_FFE4, 5'd0});
      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, e, got, to);
         n_cmp++;
         if (to || got.data !== e.data) begin
            n_bad++;
            $display("FAIL %s data: got %h want %h (timeout=%b)", tbl[i].nm, got.data, e.data, to);
         end
         n_cmp++;
         if (got.hi !== e.hi) begin
            n_bad++;
            $display("FAIL %s hi: got %h want %h", tbl[i].nm, got.hi, e.hi);
         end
         n_cmp++;
         if (got.flags !== e.flags) begin
            n_bad++;
            $display("FAIL %s flags(z,ov,dz,ill): got %b want %b", tbl[i].nm, got.flags, e.flags);
         end
         n_cmp++;
         if (got.lat !== e.lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", tbl[i].nm, got.lat, e.lat);
         end
      end
   endtask

   task automatic test_busy_ignore();
      exp_t e;
      int   cyc;
      @(negedge clk);
      aluctl = {5'd13, 1'b0}; A = 32'd100; B = 32'd7; start = 1'b1;
      sb.push_back(model(5'd13, 32'd100, 32'd7, 5'd0));
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      repeat (3) begin @(negedge clk); cyc++; end
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_in_div: got %b want 1", busy);
      end
      aluctl = {5'd15, 1'b0}; A = 32'd1; B = 32'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
      while (!alu_ready && cyc < 100) begin @(negedge clk); cyc++; end
      e = sb.pop_front();
      n_cmp++;
      if (alu_out_data !== e.data || hi_out !== e.hi) begin
         n_bad++;
         $display("FAIL busy_ignore result: got q=%h r=%h want q=%h r=%h", alu_out_data, hi_out, e.data, e.hi);
      end
      n_cmp++;
      if (cyc !== 33) begin
         n_bad++;
         $display("FAIL busy_ignore latency: got %0d want 33", cyc);
      end
      @(negedge clk);
      n_cmp++;
      if (alu_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_ignore extra_ready: got %b want 0", alu_ready);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      @(negedge clk);
      aluctl = {5'd11, 1'b0}; A = 32'd10; B = 32'd20; start = 1'b1;
      sb.push_back(model(5'd11, 32'd10, 32'd20, 5'd0));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (alu_ready !== 1'b1 || alu_out_data !== e.data) begin
         n_bad++;
         $display("FAIL b2b first: got rdy=%b data=%h want rdy=1 data=%h", alu_ready, alu_out_data, e.data);
      end
      aluctl = {5'd9, 1'b0}; A = 32'h0000_00F0; B = 32'h0000_000F;
      sb.push_back(model(5'd9, 32'h0000_00F0, 32'h0000_000F, 5'd0));
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (alu_ready !== 1'b1 || alu_out_data !== e.data) begin
         n_bad++;
         $display("FAIL b2b second: got rdy=%b data=%h want rdy=1 data=%h", alu_ready, alu_out_data, e.data);
      end
      @(negedge clk);
      n_cmp++;
      if (alu_ready !== 1'b0 || alu_out_data !== e.data) begin
         n_bad++;
         $display("FAIL b2b idle_hold: got rdy=%b data=%h want rdy=0 data=%h", alu_ready, alu_out_data, e.data);
      end
   endtask

   task automatic test_reset_mid_mul();
      logic seen;
      @(negedge clk);
      aluctl = {5'd12, 1'b0}; A = 32'hFFFF_FFFD; B = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
`ifndef ALU_FAST_MUL_EN
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_mul busy: got %b want 1", busy);
      end
`endif
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, alu_ready, alu_out_data, hi_out, zero, overflow, div_by_zero, illegal} !== '0) begin
         n_bad++;
         $display("FAIL mid_mul reset_outputs: got busy=%b rdy=%b data=%h hi=%h, want all 0",
                  busy, alu_ready, alu_out_data, hi_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (alu_ready) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_mul aborted: got alu_ready=%b after reset want 0", seen);
      end
   endtask

   task automatic test_random();
      exp_t e, got;
      logic to;
      logic [4:0] op;
      logic [31:0] a, b;
      logic [4:0] sh;
      for (int i = 0; i < 40; i++) begin
         op = 5'($urandom_range(0, 31));
         a  = $urandom;
         b  = (i % 7 == 3) ? 32'd0 : $urandom;
         sh = 5'($urandom_range(0, 31));
         run_op(op, a, b, sh, e, got, to);
         n_cmp++;
         if (to || got !== e) begin
            n_bad++;
            $display("FAIL rand op=%0d a=%h b=%h sh=%0d: got d=%h h=%h f=%b l=%0d want d=%h h=%h f=%b l=%0d",
                     op, a, b, sh, got.data, got.hi, got.flags, got.lat, e.data, e.hi, e.flags, e.lat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ops();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_mul();
      test_random();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
